// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg - shared types and encoding helpers for the fp_mul_pipe multiplier.
// Encodings are built from the exponent/mantissa widths, so one package serves
// every parametrisation of the pipeline.
package fp_mul_pkg;

    // Operand classification; subnormals are folded into FP_ZERO.
    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    // Status flags in output order {invalid, overflow, underflow, inexact}.
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Widest word the encoding helpers can build.
    localparam int FP_MAX_W = 64;

    // Exponent bias for an exponent field of exp_w bits.
    function automatic int fp_bias(input int exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

    // All-ones exponent value (Inf/NaN marker and overflow threshold).
    function automatic int fp_exp_max(input int exp_w);
        return (2 ** exp_w) - 1;
    endfunction

    // Signed zero.
    function automatic logic [FP_MAX_W-1:0] fp_zero(input logic sign, input int exp_w,
                                                    input int man_w);
        return FP_MAX_W'(sign) << (exp_w + man_w);
    endfunction

    // Signed infinity.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w,
                                                   input int man_w);
        return (FP_MAX_W'(sign) << (exp_w + man_w))
             | (FP_MAX_W'(fp_exp_max(exp_w)) << man_w);
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, mantissa MSB only.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        return (FP_MAX_W'(fp_exp_max(exp_w)) << man_w) | (FP_MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack - combinational final stage of fp_mul_pipe: normalise the raw
// mantissa product, round, detect overflow/underflow, resolve special operands
// and pack the result word with its status flags.
// Optional feature: define FPMUL_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated (round toward zero) and inexact is still reported.
module fp_round_pack
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                    i_sign,
    input  fp_class_e               i_cls_a,
    input  fp_class_e               i_cls_b,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [2*MAN_W+1:0]      i_prod,
    output logic [EXP_W+MAN_W:0]    o_prod,
    output fp_flags_t               o_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic [W-1:0]    QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [XW-2:0]   EXP_TOP = (XW-1)'(fp_exp_max(EXP_W));

    logic                 w_msb;
    logic [PW-2:0]        w_norm;
    logic [MAN_W-1:0]     w_man;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic [MAN_W:0]       w_man_r;
    logic                 w_carry;
    logic signed [XW-1:0] w_exp_n;
    logic signed [XW-1:0] w_exp_f;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_is_nan;
    logic                 w_is_inf;
    logic                 w_is_zero;
    logic [W-1:0]         w_inf_word;
    logic [W-1:0]         w_zero_word;
    logic [W-1:0]         w_norm_word;

    // Product of two 1.x mantissas lies in [1,4); a set MSB means the value is
    // 1x.xxx and needs one right shift. Left-aligning the other case instead lets
    // both share the same field positions below the implicit leading one.
    assign w_msb    = i_prod[PW-1];
    assign w_norm   = w_msb ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
    assign w_man    = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_exp_n  = i_exp + $signed({{(XW-1){1'b0}}, w_msb});

`ifdef FPMUL_RNE_EN
    // Round half to even: bump on guard unless exactly halfway with an even LSB.
    assign w_inc = w_guard & (w_sticky | w_man[0]);
`else
    // Truncation keeps bit-exact compatibility with the legacy bf16 multiply.
    assign w_inc = 1'b0;
`endif

    // A carry out of the rounded mantissa leaves the field at zero and bumps the
    // exponent, i.e. 1.111..1 rounds up to 10.000..0.
    assign w_man_r = {1'b0, w_man} + (MAN_W+1)'(w_inc);
    assign w_carry = w_man_r[MAN_W];
    assign w_exp_f = w_exp_n + $signed({{(XW-1){1'b0}}, w_carry});

    // Range checks on the final biased exponent.
    assign w_ovf = !w_exp_f[XW-1] && (w_exp_f[XW-2:0] >= EXP_TOP);
    assign w_unf = w_exp_f[XW-1] || (w_exp_f == '0);

    // Special-operand detection; ZERO*INF is an invalid operation.
    assign w_is_nan  = (i_cls_a == FP_NAN) || (i_cls_b == FP_NAN)
                    || ((i_cls_a == FP_ZERO) && (i_cls_b == FP_INF))
                    || ((i_cls_a == FP_INF)  && (i_cls_b == FP_ZERO));
    assign w_is_inf  = (i_cls_a == FP_INF)  || (i_cls_b == FP_INF);
    assign w_is_zero = (i_cls_a == FP_ZERO) || (i_cls_b == FP_ZERO);

    assign w_inf_word  = W'(fp_inf(i_sign, EXP_W, MAN_W));
    assign w_zero_word = W'(fp_zero(i_sign, EXP_W, MAN_W));
    assign w_norm_word = {i_sign, w_exp_f[EXP_W-1:0], w_man_r[MAN_W-1:0]};

    // Result select in priority order: specials, then range faults, then normal.
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves
        // it unassigned; a missing default here would infer a latch.
        o_prod  = w_norm_word;
        o_flags = '0;
        if (w_is_nan) begin
            o_prod          = QNAN;
            o_flags.invalid = 1'b1;
        end else if (w_is_inf) begin
            o_prod = w_inf_word;
        end else if (w_is_zero) begin
            o_prod = w_zero_word;
        end else if (w_ovf) begin
            o_prod           = w_inf_word;
            o_flags.overflow = 1'b1;
            o_flags.inexact  = 1'b1;
        end else if (w_unf) begin
            o_prod            = w_zero_word;
            o_flags.underflow = 1'b1;
            o_flags.inexact   = 1'b1;
        end else begin
            o_flags.inexact = w_guard | w_sticky;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe - 3-stage pipelined floating-point multiplier (default bfloat16,
// E8/M7) with valid/ready flow control and {invalid,overflow,underflow,inexact}
// status flags.
//   S1: unpack, sign, operand class, biased exponent sum
//   S2: unsigned mantissa product
//   S3: normalise/round/special-select (fp_round_pack), registered output
// Optional feature: define FPMUL_RNE_EN for round-to-nearest-even; the default
// build truncates.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_prod,
    output logic [3:0]           out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = fp_bias(EXP_W);

    // Classify one operand; exponent zero covers true zeros and flushed subnormals.
    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] m);
        if (e == '0) begin
            return FP_ZERO;
        end else if (&e) begin
            return (m == '0) ? FP_INF : FP_NAN;
        end else begin
            return FP_NORM;
        end
    endfunction

    // Flow control.
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;
    logic w_in_fire;

    // S1 unpack.
    logic                 w_sign;
    fp_class_e            w_cls_a;
    fp_class_e            w_cls_b;
    logic signed [XW-1:0] w_exp_sum;

    // Stage registers.
    logic                 r1_valid;
    logic                 r1_sign;
    fp_class_e            r1_cls_a;
    fp_class_e            r1_cls_b;
    logic signed [XW-1:0] r1_exp;
    logic [MAN_W:0]       r1_man_a;
    logic [MAN_W:0]       r1_man_b;

    logic [PW-1:0]        w_prod;

    logic                 r2_valid;
    logic                 r2_sign;
    fp_class_e            r2_cls_a;
    fp_class_e            r2_cls_b;
    logic signed [XW-1:0] r2_exp;
    logic [PW-1:0]        r2_prod;

    logic [W-1:0]         w_rp_prod;
    fp_flags_t            w_rp_flags;

    logic                 r_out_valid;
    logic [W-1:0]         r_out_prod;
    fp_flags_t            r_out_flags;

    // A stage advances when it is empty or its successor is advancing; the
    // chain starts from the consumer, so in_ready depends only on out_ready and
    // the stage valids, never on operand data.
    assign w_ld3     = !r_out_valid || out_ready;
    assign w_ld2     = !r2_valid || w_ld3;
    assign w_ld1     = !r1_valid || w_ld2;
    assign in_ready  = w_ld1;
    assign w_in_fire = in_valid && w_ld1;

    assign w_sign    = in_a[W-1] ^ in_b[W-1];
    assign w_cls_a   = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
    assign w_cls_b   = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
    // Signed sum with two spare bits so both overflow and underflow stay visible.
    assign w_exp_sum = $signed({2'b00, in_a[W-2:MAN_W]})
                     + $signed({2'b00, in_b[W-2:MAN_W]})
                     - $signed(XW'(BIAS));

    assign w_prod = PW'(r1_man_a) * PW'(r1_man_b);

    // Stage valid bits: cleared by reset, advanced by the load chain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignments so every stage samples
        // its predecessor's pre-edge value regardless of statement order.
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
        end else begin
            if (w_ld1) r1_valid <= in_valid;
            if (w_ld2) r2_valid <= r1_valid;
        end
    end

    // S1 operand capture on an accepted transfer.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; their contents are ignored
        // until the matching valid bit, which is reset, says otherwise.
        if (w_in_fire) begin
            r1_sign  <= w_sign;
            r1_cls_a <= w_cls_a;
            r1_cls_b <= w_cls_b;
            r1_exp   <= w_exp_sum;
            r1_man_a <= {1'b1, in_a[MAN_W-1:0]};
            r1_man_b <= {1'b1, in_b[MAN_W-1:0]};
        end
    end

    // S2 mantissa product capture when S1 holds data and S2 may advance.
    always_ff @(posedge clk) begin
        if (w_ld2 && r1_valid) begin
            r2_sign  <= r1_sign;
            r2_cls_a <= r1_cls_a;
            r2_cls_b <= r1_cls_b;
            r2_exp   <= r1_exp;
            r2_prod  <= w_prod;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign  (r2_sign),
        .i_cls_a (r2_cls_a),
        .i_cls_b (r2_cls_b),
        .i_exp   (r2_exp),
        .i_prod  (r2_prod),
        .o_prod  (w_rp_prod),
        .o_flags (w_rp_flags)
    );

    // S3 output register: holds while the consumer stalls, clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_flags <= '0;
        end else if (w_ld3) begin
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_prod  <= w_rp_prod;
                r_out_flags <= w_rp_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe - scoreboard bench for fp_mul_pipe (bf16 defaults).
// The driver pushes each expected result when its operand pair is accepted;
// an independent monitor pops and compares whenever a result is transferred.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [3:0]  out_flags;

    typedef struct {
        string       name;
        logic [15:0] prod;
        logic [3:0]  flags;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

`ifdef FPMUL_RNE_EN
    localparam logic [15:0] EXP_3FC1_SQ = 16'h4012;
    localparam logic [15:0] EXP_CARRY   = 16'h4000;
`else
    localparam logic [15:0] EXP_3FC1_SQ = 16'h4011;
    localparam logic [15:0] EXP_CARRY   = 16'h3FFF;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_flags (out_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one operand pair (called at posedge+1) and push its expectation on acceptance.
    task automatic send(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p, input logic [3:0] f, input bit lat);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            e.name    = name;
            e.prod    = p;
            e.flags   = f;
            e.acc_cyc = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for every expected result to be consumed.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: compare each transferred result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {16'd0, out_prod}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check({e.name, "_prod"}, out_prod, e.prod);
                check({e.name, "_flags"}, out_flags, e.flags);
                if (e.chk_lat) check({e.name, "_latency"}, cyc - e.acc_cyc, 3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state.
        #1 rst_n = 1'b0;
        #11;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_prod", out_prod, 0);
        check("reset_out_flags", out_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // Directed vectors, back to back with the consumer always ready.
        send("mul_1p5",      16'h3FC0, 16'h3FC0, 16'h4010,    4'b0000, 1);
        send("round_3fc1",   16'h3FC1, 16'h3FC1, EXP_3FC1_SQ, 4'b0001, 1);
        send("round_carry",  16'h3FFE, 16'h3F81, EXP_CARRY,   4'b0001, 1);
        send("ovf_big",      16'h7F00, 16'h7F00, 16'h7F80,    4'b0101, 1);
        send("ovf_edge",     16'h7F00, 16'h4000, 16'h7F80,    4'b0101, 1);
        send("max_no_ovf",   16'h7F00, 16'h3F80, 16'h7F00,    4'b0000, 1);
        send("unf_edge",     16'h0080, 16'h3F00, 16'h0000,    4'b0011, 1);
        send("min_normal",   16'h0080, 16'h3F80, 16'h0080,    4'b0000, 1);
        send("inf_x_zero",   16'h7F80, 16'h0000, 16'h7FC0,    4'b1000, 1);
        send("zero_x_ninf",  16'h0000, 16'hFF80, 16'h7FC0,    4'b1000, 1);
        send("nan_operand",  16'h7FC1, 16'h3F80, 16'h7FC0,    4'b1000, 1);
        send("ninf_x_2",     16'hFF80, 16'h4000, 16'hFF80,    4'b0000, 1);
        send("ninf_x_inf",   16'hFF80, 16'h7F80, 16'hFF80,    4'b0000, 1);
        send("nzero_x_1",    16'h8000, 16'h3F80, 16'h8000,    4'b0000, 1);
        send("subnorm_flush",16'h0001, 16'h3F80, 16'h0000,    4'b0000, 1);
        send("neg_one",      16'hBF80, 16'h3F80, 16'hBF80,    4'b0000, 1);
        drain("directed");

        // Backpressure: consumer stalled for 5 cycles while 6 ops stream in.
        out_ready = 1'b0;
        acc_cnt   = 0;
        fork
            begin
                send("s0", 16'h3F80, 16'h4000, 16'h4000, 4'b0000, 0);
                send("s1", 16'h4040, 16'h4000, 16'h40C0, 4'b0000, 0);
                send("s2", 16'hBF80, 16'h3F80, 16'hBF80, 4'b0000, 0);
                send("s3", 16'h4040, 16'h4040, 16'h4110, 4'b0000, 0);
                send("s4", 16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 0);
                send("s5", 16'h4080, 16'hC000, 16'hC100, 4'b0000, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_accepted", acc_cnt, 3);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain("stream");

        // Reset with two operations in flight.
        send("rst_op0", 16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000, 0);
        send("rst_op1", 16'h4040, 16'h4040, 16'h4110, 4'b0000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_prod", out_prod, 0);
        check("midrst_out_flags", out_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_result", seen, 0);
        @(posedge clk);
        #1;
        send("post_reset", 16'h4040, 16'h4040, 16'h4110, 4'b0000, 1);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
